// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and hardwired x0.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int MON_REG       = 10
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data_o,
    output logic [NUM_READ-1:0]               rd_busy_o,
    input  logic                              wr_en_i,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              rsv_en_i,
    input  logic [ADDRESS_WIDTH-1:0]          rsv_addr_i,
    output logic                              rsv_ok_o,
    output logic [2**ADDRESS_WIDTH-1:0]       busy_o,
    output logic [DATA_WIDTH-1:0]             mon_o
);

    localparam int NUM_REGS = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] MON_IDX = ADDRESS_WIDTH'(MON_REG);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_r;
    logic                  rsv_ok_s;
    logic                  wr_act_s;

    // Reservation decision uses only the registered busy state, never the read addresses.
    always_comb begin
        rsv_ok_s = 1'b0;
        if (rsv_en_i) begin
            rsv_ok_s = (rsv_addr_i == '0) || !busy_r[rsv_addr_i];
        end else begin
            rsv_ok_s = 1'b0;
        end
    end

    assign wr_act_s = wr_en_i && (wr_addr_i != '0);

    // Register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_act_s) begin
            regs_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Scoreboard: writeback clears, an accepted reservation sets afterwards so set wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= '0;
        end else begin
            if (wr_act_s) begin
                busy_r[wr_addr_i] <= 1'b0;
            end
            if (rsv_ok_s && (rsv_addr_i != '0)) begin
                busy_r[rsv_addr_i] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0]    data_s;
        logic                     busy_s;

        assign addr_s = rd_addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Read mux for one port, with optional forwarding of the in-flight writeback.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (addr_s == '0) begin
                data_s = '0;
                busy_s = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (wr_en_i && (wr_addr_i == addr_s)) begin
                data_s = wr_data_i;
                busy_s = 1'b0;
            end
`endif
            else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_s;
        assign rd_busy_o[k]                          = busy_s;
    end

    assign rsv_ok_o = rsv_ok_s;
    assign busy_o   = busy_r;
    assign mon_o    = regs_r[MON_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NREG = 32;

    logic             clk;
    logic             rst_n;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_ok;
    logic [NREG-1:0]  busy;
    logic [DW-1:0]    mon;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_busy;

    regfile_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .MON_REG(10)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok), .busy_o(busy), .mon_o(mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_rsv_ok();
        return rsv_en && (rsv_addr == 5'd0 || !m_busy[rsv_addr]);
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s rd_data%0d", tag, k), 64'(rd_data[k*DW +: DW]), 64'(exp_data(rd_addr[k*AW +: AW])));
            chk($sformatf("%s rd_busy%0d", tag, k), 64'(rd_busy[k]), 64'(exp_busy(rd_addr[k*AW +: AW])));
        end
        chk({tag, " rsv_ok"}, 64'(rsv_ok), 64'(exp_rsv_ok()));
        chk({tag, " busy_o"}, 64'(busy), 64'(m_busy));
        chk({tag, " mon_o"}, 64'(mon), 64'(m_regs[10]));
    endtask

    // One cycle: settle, compare, clock, then advance the model with the held inputs.
    task automatic step(input string tag);
        logic ok;
        #2;
        check_all(tag);
        ok = exp_rsv_ok();
        @(posedge clk);
        if (wr_en && wr_addr != 5'd0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (ok && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        idle();
        model_clear();
        #2;
        for (int a = 0; a < NREG; a++) begin
            for (int k = 0; k < NR; k++) set_rd(k, 5'(a));
            rsv_en = a[0];
            #1;
            check_all("reset");
        end
        rsv_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hDEADBEEF;
        step("wr_x10");
        wr_addr = 5'd0; wr_data = 32'h12345678;
        step("wr_x0");
        idle(); set_rd(0, 5'd10); set_rd(1, 5'd0);
        #2;
        chk("x10 value", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("x0 value", 64'(rd_data[63:32]), 64'h0);
        chk("mon a0", 64'(mon), 64'h0000_0000_DEAD_BEEF);
        step("read_back");

        rsv_en = 1'b1; rsv_addr = 5'd5; set_rd(0, 5'd5);
        #2; chk("rsv x5 first", 64'(rsv_ok), 64'h1);
        step("rsv5a");
        chk("rsv x5 again", 64'(rsv_ok), 64'h0);
        chk("busy5 set", 64'(busy[5]), 64'h1);
        chk("rd_busy x5", 64'(rd_busy[0]), 64'h1);
        step("rsv5b");
        idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5;
        step("wr5");
        idle();
        #2;
        chk("busy5 clear", 64'(busy[5]), 64'h0);
        chk("x5 value", 64'(rd_data[31:0]), 64'hA5);
        step("after_wr5");

        rsv_en = 1'b1; rsv_addr = 5'd7;
        step("rsv7");
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #2; chk("x7 wr+rsv ok", 64'(rsv_ok), 64'h0);
        step("wr_rsv7");
        rsv_addr = 5'd8; wr_addr = 5'd8; wr_data = 32'h88;
        #2;
        chk("busy7 after", 64'(busy[7]), 64'h0);
        chk("x8 wr+rsv ok", 64'(rsv_ok), 64'h1);
        step("wr_rsv8");
        idle();
        #2; chk("busy8 after", 64'(busy[8]), 64'h1);
        step("after8");

        rsv_en = 1'b1; rsv_addr = 5'd3;
        step("rsv3");
        idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; set_rd(1, 5'd3);
        #2;
`ifdef REGFILE_BYPASS_EN
        chk("bypass x3 data", 64'(rd_data[63:32]), 64'h33);
        chk("bypass x3 busy", 64'(rd_busy[1]), 64'h0);
`else
        chk("nobypass x3 data", 64'(rd_data[63:32]), 64'h0);
        chk("nobypass x3 busy", 64'(rd_busy[1]), 64'h1);
`endif
        step("wr3");

        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 5'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
            wr_data  = $urandom;
            rsv_en   = ($urandom_range(0, 2) != 0);
            rsv_addr = 5'($urandom_range(0, 7));
            for (int k = 0; k < NR; k++) set_rd(k, 5'($urandom_range(0, (n % 3 == 0) ? 31 : 7)));
            step("random");
        end

        idle(); rsv_en = 1'b1; rsv_addr = 5'd4;
        step("rsv4");
        idle(); wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        step("wr6");
        chk("busy4 before reset", 64'(busy[4]), 64'h1);
        rsv_en = 1'b1; rsv_addr = 5'd9; wr_addr = 5'd11; wr_data = 32'h1111;
        #1; rst_n = 1'b0; #1;
        model_clear();
        chk("busy_o async reset", 64'(busy), 64'h0);
        for (int a = 0; a < NREG; a++) begin
            for (int k = 0; k < NR; k++) set_rd(k, 5'(a));
            #1;
            check_all("async_reset");
        end
        @(posedge clk); #1;
        idle(); rst_n = 1'b1;
        set_rd(0, 5'd11); set_rd(1, 5'd6);
        step("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated per-register scoreboard, replacing the two-read-port register file in the next-generation pipelined core. Decode reserves a destination register at issue; the register is busy until writeback writes it, and every read port reports whether its source is still pending so the hazard unit can stall. x0 is hardwired to zero, and an optional same-cycle write-to-read bypass removes one stall cycle at writeback.

## Interface
- ADDRESS_WIDTH, 5: register address width; 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32: register width.
- NUM_READ, 2: number of read ports, 1..4.
- MON_REG, 10: index of the register driven on mon_o (a0 by default).

- clk_i  input  1  clock; all state updates on posedge.
- rst_ni  input  1  reset; asynchronous, active-low.
- rd_addr_i  input  NUM_READ*ADDRESS_WIDTH  read addresses; port k at bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rd_data_o  output  NUM_READ*DATA_WIDTH  read data, combinational; port k at [k*DATA_WIDTH +: DATA_WIDTH].
- rd_busy_o  output  NUM_READ  port k's source register has a pending write.
- wr_en_i  input  1  writeback enable.
- wr_addr_i  input  ADDRESS_WIDTH  writeback address.
- wr_data_i  input  DATA_WIDTH  writeback data.
- rsv_en_i  input  1  reserve request from issue.
- rsv_addr_i  input  ADDRESS_WIDTH  register to reserve.
- rsv_ok_o  output  1  reservation accepted this cycle (combinational).
- busy_o  output  2**ADDRESS_WIDTH  scoreboard vector, registered; bit 0 always 0.
- mon_o  output  DATA_WIDTH  contents of register MON_REG, combinational from storage.

## Operation
- Storage: 2**ADDRESS_WIDTH x DATA_WIDTH registers, busy bit per register.
- Write: on posedge with wr_en_i=1 and wr_addr_i!=0, reg[wr_addr_i]<=wr_data_i and busy[wr_addr_i]<=0. Writing a non-busy register is legal. Address 0 is ignored.
- Reserve: rsv_ok_o = rsv_en_i && (rsv_addr_i==0 || !busy[rsv_addr_i]), using the current registered busy value. When rsv_ok_o=1 and rsv_addr_i!=0, busy[rsv_addr_i]<=1. Reserving x0 is accepted with no state change. A refused reservation changes no state; issue must retry.
- Same register written and reserved in one cycle:
  - Busy register: the write clears busy and the reservation is refused. busy ends at 0.
  - Non-busy register: the reservation is accepted and busy ends at 1, so the set wins.
- Read port k:
  - Address 0: rd_data=0, rd_busy=0.
  - Otherwise: rd_data=reg[addr] and rd_busy=busy[addr], subject to the bypass described under Configuration.
- Any number of ports may read the same address.

## Timing
- Reset (rst_ni low, asynchronous): all registers 0 and all busy bits 0. Therefore rd_data_o=0, rd_busy_o=0, busy_o=0, mon_o=0. rsv_ok_o follows rsv_en_i.
- Reset asserted mid-operation clears all state immediately. A write or reservation in the same cycle is lost.
- Write latency: 1 cycle. Data is visible on reads the cycle after the write edge, or in the same cycle with bypass.
- Reserve latency: busy is visible on rd_busy_o/busy_o the cycle after acceptance.
- No combinational path from rd_addr_i to rsv_ok_o.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When wr_en_i=1 and wr_addr_i==rd_addr_k!=0, port k returns wr_data_i and rd_busy_k=0 in that same cycle.
  - mon_o is not bypassed.
- REGFILE_BYPASS_EN undefined:
  - Port k returns the stored value and rd_busy_k=busy[addr] during the write cycle.
  - A pending writeback therefore costs one extra stall cycle.

## Test plan
- Reset, then read all addresses on every port -> all data 0, rd_busy_o=0, busy_o=0, mon_o=0.
- Write 0xDEADBEEF to x10, then write 0x12345678 to x0. Next cycle, read x10 and x0 -> 0xDEADBEEF and 0. mon_o=0xDEADBEEF.
- Reserve x5 (rsv_ok_o=1), then reserve x5 again -> second rsv_ok_o=0. busy_o[5]=1. A read of x5 shows rd_busy=1 until a write of 0xA5 to x5; the cycle after, busy_o[5]=0 and data is 0xA5.
- Busy x7 written (0x77) and re-reserved in the same cycle -> rsv_ok_o=0, busy_o[7]=0 next cycle. Non-busy x8 written and reserved in the same cycle -> rsv_ok_o=1, busy_o[8]=1 next cycle.
- Busy x3, write 0x33 while port 1 reads x3:
  - With REGFILE_BYPASS_EN: rd_data=0x33, rd_busy=0 that cycle.
  - Without it: old value, rd_busy=1.
- Reserve x4 and write x6 (0x66), then drop rst_ni mid-cycle -> busy_o and all registers read 0 immediately, with no clock edge needed.
